// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer block: state encoding and default width.
package down_timer_pkg;

  // Default counter width; any value of 2 or more works.
  localparam int DEFAULT_WIDTH = 4;

  // Controller states. busy is asserted only in ST_RUN.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/down_timer_tff_load.sv
// T flip-flop with asynchronous active-high clear, synchronous parallel load
// and toggle enable. The down_timer builds its decrement chain from these cells.
module down_timer_tff_load (
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  logic d,
  input  logic t,
  output logic q
);

  // Clear wins, then parallel load, then toggle.
  always_ff @(posedge clk or posedge clear) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (clear) begin
      q <= 1'b0;
    end else if (load) begin
      q <= d;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counter/timer with terminal-count flag, one-cycle done pulse
// and optional automatic reload for periodic ticks. The count itself lives in
// a ripple-borrow chain of T flip-flops; the controller and done register are
// kept here.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  logic             running;
  logic             step;
  logic             terminal;
  logic             reload_now;
  logic             run_en;
  logic             par_load;
  logic [WIDTH-1:0] par_val;
  logic [WIDTH-1:0] tgl;

  // An enabled RUN cycle that is not overridden by load. The q != 0 term is a
  // guard against wrap-around; RUN is never entered with a zero count.
  assign running    = (state == ST_RUN);
  assign step       = running & en & ~load & (q != '0);
  assign terminal   = step & (q == WIDTH'(1));
  assign reload_now = terminal & auto_reload;

  // Decrement unless the terminal cycle reloads. The one-shot terminal cycle
  // decrements 1 -> 0 through the chain like any other step.
  assign run_en   = step & ~reload_now;
  assign par_load = load | reload_now;
  assign par_val  = load ? load_val : reload_reg;

  // Stage i toggles when every lower bit is zero (borrow ripples through).
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i == 0) begin : g_lsb
      assign tgl[i] = run_en;
    end else begin : g_upper
      assign tgl[i] = run_en & (q[i-1:0] == '0);
    end

    down_timer_tff_load u_tff (
      .clk   (clk),
      .clear (clear),
      .load  (par_load),
      .d     (par_val[i]),
      .t     (tgl[i]),
      .q     (q[i])
    );
  end

  assign busy = running;
  assign tc   = (q == '0);

  // Controller: state, reload value and the registered done pulse.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= ST_IDLE;
      reload_reg <= '0;
      done       <= 1'b0;
    end else if (load) begin
      reload_reg <= load_val;
      done       <= 1'b0;
      state      <= (load_val != '0) ? ST_RUN : ST_IDLE;
    end else if (terminal) begin
      done <= 1'b1;
      if (!auto_reload) begin
        state <= ST_EXPIRED;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_down_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clear = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] q;
  logic         busy;
  logic         tc;
  logic         done;

  int total = 0;
  int bad   = 0;

  // Behavioural model: count, reload value, running flag, done pulse.
  int m_q    = 0;
  int m_rel  = 0;
  bit m_run  = 1'b0;
  bit m_done = 1'b0;

  down_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .clear       (clear),
    .en          (en),
    .load        (load),
    .load_val    (load_val),
    .auto_reload (auto_reload),
    .q           (q),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Observable outputs packed as {q, busy, tc, done}.
  function automatic logic [W+2:0] obs();
    return {q, busy, tc, done};
  endfunction

  function automatic logic [W+2:0] want(int eq, bit eb, bit ed);
    return {W'(eq), eb, (eq == 0), ed};
  endfunction

  task automatic model_clear();
    m_q = 0; m_rel = 0; m_run = 1'b0; m_done = 1'b0;
  endtask

  // One clock of the timer rules: load beats count; terminal count pulses done.
  task automatic model_step();
    if (load) begin
      m_q = int'(load_val); m_rel = int'(load_val);
      m_run = (load_val != 0); m_done = 1'b0;
    end else if (m_run && en) begin
      if (m_q == 1) begin
        m_done = 1'b1;
        if (auto_reload) m_q = m_rel;
        else begin m_q = 0; m_run = 1'b0; end
      end else begin
        m_q = m_q - 1; m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
  endtask

  // Advance one clock; inputs are stable across the posedge, outputs are
  // observed at the following negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3 clear = 1'b1;
    #1;
    total++;
    if (obs() !== want(0, 0, 0)) begin
      bad++; $display("FAIL reset_async: got %b want %b", obs(), want(0, 0, 0));
    end
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    tick();
    total++;
    if (obs() !== want(0, 0, 0)) begin
      bad++; $display("FAIL reset_release: got %b want %b", obs(), want(0, 0, 0));
    end
  endtask

  task automatic test_one_shot();
    load = 1'b1; load_val = W'(5); en = 1'b1; auto_reload = 1'b0;
    tick();
    load = 1'b0;
    total++;
    if (obs() !== want(5, 1, 0)) begin
      bad++; $display("FAIL oneshot_load: got %b want %b", obs(), want(5, 1, 0));
    end
    for (int e = 4; e >= 0; e--) begin
      tick();
      total++;
      if (obs() !== want(e, e != 0, e == 0)) begin
        bad++; $display("FAIL oneshot_q%0d: got %b want %b", e, obs(), want(e, e != 0, e == 0));
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (obs() !== want(0, 0, 0)) begin
        bad++; $display("FAIL oneshot_expired: got %b want %b", obs(), want(0, 0, 0));
      end
    end
  endtask

  task automatic test_periodic();
    int e;
    load = 1'b1; load_val = W'(3); en = 1'b1; auto_reload = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (obs() !== want(3, 1, 0)) begin
      bad++; $display("FAIL periodic_load: got %b want %b", obs(), want(3, 1, 0));
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      e = (i % 3 == 0) ? 2 : (i % 3 == 1) ? 1 : 3;
      total++;
      if (obs() !== want(e, 1, i % 3 == 2)) begin
        bad++; $display("FAIL periodic3_c%0d: got %b want %b", i, obs(), want(e, 1, i % 3 == 2));
      end
    end
    load = 1'b1; load_val = W'(1);
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (obs() !== want(1, 1, 1)) begin
        bad++; $display("FAIL periodic1_c%0d: got %b want %b", i, obs(), want(1, 1, 1));
      end
    end
  endtask

  task automatic test_gated();
    int e;
    load = 1'b1; load_val = W'(4); en = 1'b0; auto_reload = 1'b0;
    tick();
    load = 1'b0;
    for (int c = 0; c < 8; c++) begin
      en = (c % 2 == 0);
      tick();
      e = 4 - (c / 2 + 1);
      total++;
      if (obs() !== want(e, c < 6, c == 6)) begin
        bad++; $display("FAIL gated_c%0d: got %b want %b", c, obs(), want(e, c < 6, c == 6));
      end
    end
  endtask

  task automatic test_collisions();
    load = 1'b1; load_val = W'(9); en = 1'b1; auto_reload = 1'b0;
    tick();
    load = 1'b0;
    total++;
    if (obs() !== want(9, 1, 0)) begin
      bad++; $display("FAIL coll_load_en: got %b want %b", obs(), want(9, 1, 0));
    end
    repeat (7) tick();
    total++;
    if (obs() !== want(2, 1, 0)) begin
      bad++; $display("FAIL coll_reach2: got %b want %b", obs(), want(2, 1, 0));
    end
    load = 1'b1; load_val = W'(7);
    tick();
    total++;
    if (obs() !== want(7, 1, 0)) begin
      bad++; $display("FAIL coll_reload_run: got %b want %b", obs(), want(7, 1, 0));
    end
    load_val = '0;
    tick();
    load = 1'b0;
    total++;
    if (obs() !== want(0, 0, 0)) begin
      bad++; $display("FAIL coll_load_zero: got %b want %b", obs(), want(0, 0, 0));
    end
    repeat (3) tick();
    total++;
    if (obs() !== want(0, 0, 0)) begin
      bad++; $display("FAIL coll_idle_hold: got %b want %b", obs(), want(0, 0, 0));
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    load = 1'b1; load_val = W'(6); en = 1'b0; auto_reload = 1'b0;
    tick();
    load = 1'b0;
    total++;
    if (obs() !== want(6, 1, 0)) begin
      bad++; $display("FAIL midrst_load: got %b want %b", obs(), want(6, 1, 0));
    end
    #1 clear = 1'b1;
    #2;
    total++;
    if (obs() !== want(0, 0, 0)) begin
      bad++; $display("FAIL midrst_async: got %b want %b", obs(), want(0, 0, 0));
    end
    clear = 1'b0;
    model_clear();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) pulses++;
    end
    total++;
    if (obs() !== want(0, 0, 0) || pulses != 0) begin
      bad++; $display("FAIL midrst_after: got %b pulses=%0d want %b pulses=0", obs(), pulses, want(0, 0, 0));
    end
  endtask

  task automatic test_random();
    auto_reload = 1'b0;
    for (int i = 0; i < 600; i++) begin
      load     = ($urandom_range(0, 19) == 0);
      load_val = W'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) auto_reload = ~auto_reload;
      if ($urandom_range(0, 79) == 0) begin
        #2 clear = 1'b1;
        #2 clear = 1'b0;
        model_clear();
        total++;
        if (obs() !== want(0, 0, 0)) begin
          bad++; $display("FAIL rand_clear_%0d: got %b want %b", i, obs(), want(0, 0, 0));
        end
      end
      tick();
      total++;
      if (obs() !== want(m_q, m_run, m_done)) begin
        bad++; $display("FAIL rand_c%0d: got %b want %b", i, obs(), want(m_q, m_run, m_done));
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_gated();
    test_collisions();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
